apb_periph_fabric: RTL and testbench
====================================

# apb_periph_fabric

Parametrised APB fabric with one manager port and `NrPerip` subordinate ports, sitting between the core's APB manager and the SoC peripherals (UART, mtimer, future blocks). It decodes each transfer against a run-time address map, lowest matching index winning. It re-times the transfer onto the selected subordinate through a registered setup/access sequence. Unmapped addresses and stalled subordinates get a defined error response instead of a silent `pready = 1`.

## Interface
- `NrPerip`, 4: number of subordinate ports, 1..16
- `AddrWidth`, 32: APB address width
- `DataWidth`, 32: APB data width
- `TimeoutCycles`, 255: max ACCESS cycles before abort, ≥1; counter width `$clog2(TimeoutCycles+1)`
- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `s_psel_i`, `s_penable_i`, `s_pwrite_i` in 1 each: manager control
- `s_paddr_i` in `AddrWidth`: manager address
- `s_pwdata_i` in `DataWidth`: manager write data
- `s_prdata_o` out `DataWidth`: read data to manager
- `s_pready_o`, `s_pslverr_o` out 1 each: manager response
- `addr_base_i` in `NrPerip*AddrWidth`: per-port base, inclusive, slice i = port i
- `addr_last_i` in `NrPerip*AddrWidth`: per-port end, exclusive
- `m_psel_o` out `NrPerip`: one-hot subordinate select
- `m_penable_o`, `m_pwrite_o` out 1 each: broadcast control
- `m_paddr_o` out `AddrWidth`, `m_pwdata_o` out `DataWidth`: broadcast, registered
- `m_prdata_i` in `NrPerip*DataWidth`; `m_pready_i`, `m_pslverr_i` in `NrPerip`: subordinate responses
- `err_valid_o` out 1: one-cycle pulse on any error response
- `err_addr_o` out `AddrWidth`: address of last errored transfer

## Operation
- FSM states: IDLE, SETUP, ACCESS, ERR.
- **IDLE**
  - On `s_psel_i && !s_penable_i`, latch `paddr`, `pwrite` and `pwdata` into the broadcast registers.
  - Decode port i where `base_i <= paddr < last_i`. The lowest i wins. A range with `base >= last` never matches.
  - On a hit, latch the index and go to SETUP. On a miss, go to ERR.
  - `s_psel_i && s_penable_i` seen in IDLE is a protocol violation and is ignored.
- **SETUP**: `m_psel_o[idx] = 1`, `m_penable_o = 0`; go to ACCESS.
- **ACCESS**
  - `m_psel_o[idx] = 1`, `m_penable_o = 1`.
  - `s_pready_o`, `s_prdata_o` and `s_pslverr_o` pass through combinationally from port idx.
  - On `m_pready_i[idx]`, go to IDLE. If `m_pslverr_i[idx]` is also high, pulse `err_valid_o` and capture `err_addr_o`.
- **ERR**: `s_pready_o = 1`, `s_pslverr_o = 1`, `s_prdata_o = 0`, no `m_psel_o` asserted. Pulse `err_valid_o`, capture address, go to IDLE.
- Outside ACCESS and ERR: `s_pready_o = 0`, `s_pslverr_o = 0`, `s_prdata_o = 0`.
- A write to an unmapped address has no side effect.
- The address map is sampled only in IDLE at the setup cycle. Changes during a transfer do not affect it.

## Timing
- Reset values: state IDLE, all `m_psel_o = 0`, `m_penable_o = 0`, broadcast registers 0, `s_pready_o = 0`, `s_pslverr_o = 0`, `err_valid_o = 0`, `err_addr_o = 0`, timeout counter 0.
- Reset is synchronous and takes priority over everything. Asserted mid-transfer, `m_psel_o` drops at the next edge, no response is given to the manager, and the subordinate transfer is abandoned.
- Mapped transfer with a zero-wait subordinate:
  - manager setup at cycle 0, fabric SETUP at cycle 1 (manager wait state), ACCESS at cycle 2 with `s_pready_o = 1`;
  - one added wait state, every subordinate wait state adds 1.
- Unmapped transfer: ERR at cycle 1. The manager sees `pready` and `pslverr` in its first access cycle, with zero wait states.
- Back-to-back: a new setup is accepted in the cycle immediately after `s_pready_o`.
- `err_valid_o` is high exactly one cycle, the same cycle as the erroring `s_pready_o`.

## Configuration
- `APB_FABRIC_TIMEOUT_EN` defined:
  - the counter clears on SETUP entry and increments each ACCESS cycle without `m_pready_i[idx]`;
  - when it equals `TimeoutCycles` with no `pready`, that cycle drives `s_pready_o = 1`, `s_pslverr_o = 1`, `s_prdata_o = 0`, pulses `err_valid_o` and goes to IDLE;
  - `m_psel_o` drops next cycle; a subordinate `pready` arriving in the timeout cycle takes priority.
- Undefined: no counter logic, and ACCESS waits indefinitely.

## Test plan
- Map port1 `[0x0003_0000, 0x0003_0100)`. Read `0x0003_0010`, port1 returns `0xDEAD_BEEF` with zero wait → manager gets `0xDEAD_BEEF`, `pslverr = 0`, `s_pready_o` at cycle 2, `m_psel_o = 4'b0010` in cycles 1–2.
- Write `0x0009_0000`, unmapped → `s_pready_o = 1`, `pslverr = 1` at cycle 1. No `m_psel_o` asserted, `err_valid_o` pulses once, `err_addr_o = 0x0009_0000`.
- Overlap: port0 `[0x1000, 0x2000)`, port2 `[0x1800, 0x1900)`, access `0x1880` → `m_psel_o = 4'b0001`.
- Timeout enabled, `TimeoutCycles = 4`, port stalls → `pslverr = 1` with `pready` at ACCESS cycle 4, then `m_psel_o = 0`. Second run with `pready` in cycle 4 → normal response, no error.
- Assert `rst_i` during ACCESS → next edge all outputs at reset values. A following transfer completes normally.
- Two back-to-back reads to port0 and port3 → second setup accepted the cycle after first `pready`, both return correct data.

Source files
------------

// File: rtl/apb_periph_fabric.sv
// APB fabric: one manager fanned out to NrPerip subordinates, decoded against a run-time address map.
// Optional build macro APB_FABRIC_TIMEOUT_EN aborts subordinates that stall longer than TimeoutCycles.
module apb_periph_fabric #(
  parameter int NrPerip       = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_psel_i,
  input  logic                           s_penable_i,
  input  logic                           s_pwrite_i,
  input  logic [AddrWidth-1:0]           s_paddr_i,
  input  logic [DataWidth-1:0]           s_pwdata_i,
  output logic [DataWidth-1:0]           s_prdata_o,
  output logic                           s_pready_o,
  output logic                           s_pslverr_o,
  input  logic [NrPerip*AddrWidth-1:0]   addr_base_i,
  input  logic [NrPerip*AddrWidth-1:0]   addr_last_i,
  output logic [NrPerip-1:0]             m_psel_o,
  output logic                           m_penable_o,
  output logic                           m_pwrite_o,
  output logic [AddrWidth-1:0]           m_paddr_o,
  output logic [DataWidth-1:0]           m_pwdata_o,
  input  logic [NrPerip*DataWidth-1:0]   m_prdata_i,
  input  logic [NrPerip-1:0]             m_pready_i,
  input  logic [NrPerip-1:0]             m_pslverr_i,
  output logic                           err_valid_o,
  output logic [AddrWidth-1:0]           err_addr_o
);

  localparam int IdxW = (NrPerip > 1) ? $clog2(NrPerip) : 1;

  // Out-of-range parameters leave an empty marker block in the elaborated hierarchy.
  if (TimeoutCycles < 1 || NrPerip < 1 || NrPerip > 16) begin : g_param_out_of_range
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t                r_state;
  logic [NrPerip-1:0]    r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [AddrWidth-1:0]  r_paddr;
  logic [DataWidth-1:0]  r_pwdata;
  logic [AddrWidth-1:0]  r_err_addr;
  logic [IdxW-1:0]       r_idx;

  logic                  w_hit;
  logic [IdxW-1:0]       w_hit_idx;
  logic [NrPerip-1:0]    w_hit_sel;
  logic [DataWidth-1:0]  w_sel_rdata;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic                  w_access;
  logic                  w_err_state;
  logic                  w_timeout;
  logic                  w_resp_ready;
  logic                  w_resp_err;
  logic                  w_done;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_hit_sel = '0;
    for (int i = NrPerip - 1; i >= 0; i--) begin
      if ((s_paddr_i >= addr_base_i[i*AddrWidth +: AddrWidth]) &&
          (s_paddr_i <  addr_last_i[i*AddrWidth +: AddrWidth])) begin
        w_hit        = 1'b1;
        w_hit_idx    = IdxW'(i);
        w_hit_sel    = '0;
        w_hit_sel[i] = 1'b1;
      end
    end
  end

  assign w_sel_rdata = m_prdata_i[r_idx*DataWidth +: DataWidth];
  assign w_sel_ready = m_pready_i[r_idx];
  assign w_sel_err   = m_pslverr_i[r_idx];
  assign w_access    = (r_state == ACCESS);
  assign w_err_state = (r_state == ERR);

`ifdef APB_FABRIC_TIMEOUT_EN
  localparam int                CntW       = $clog2(TimeoutCycles + 1);
  localparam logic [CntW:0]     TimeoutVal = (CntW + 1)'(TimeoutCycles);
  logic [CntW-1:0] r_cnt;
  logic [CntW:0]   w_cnt_inc;

  // The cycle whose increment would reach TimeoutCycles is the abort cycle.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CntW{1'b0}}, 1'b1};
  assign w_timeout = w_access && !w_sel_ready && (w_cnt_inc == TimeoutVal);
`else
  assign w_timeout = 1'b0;
`endif

  // Responses are suppressed while reset is asserted: an abandoned transfer never answers.
  assign w_resp_ready = (w_access && (w_sel_ready || w_timeout)) || w_err_state;
  assign w_resp_err   = (w_access && (w_timeout || w_sel_err)) || w_err_state;
  assign w_done       = w_access && (w_sel_ready || w_timeout);

  assign s_pready_o   = !rst_i && w_resp_ready;
  assign s_pslverr_o  = !rst_i && w_resp_err;
  assign s_prdata_o   = (w_access && !w_timeout) ? w_sel_rdata : '0;
  assign err_valid_o  = !rst_i && w_resp_ready && w_resp_err;

  assign m_psel_o     = r_psel;
  assign m_penable_o  = r_penable;
  assign m_pwrite_o   = r_pwrite;
  assign m_paddr_o    = r_paddr;
  assign m_pwdata_o   = r_pwdata;
  assign err_addr_o   = r_err_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_err_addr <= '0;
      r_idx      <= '0;
`ifdef APB_FABRIC_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // A setup phase starts a transfer; a bare access phase here is ignored.
          if (s_psel_i && !s_penable_i) begin
            r_paddr  <= s_paddr_i;
            r_pwrite <= s_pwrite_i;
            r_pwdata <= s_pwdata_i;
            if (w_hit) begin
              r_idx   <= w_hit_idx;
              r_psel  <= w_hit_sel;
              r_state <= SETUP;
`ifdef APB_FABRIC_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end else begin
              r_state <= ERR;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_done) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= IDLE;
            if (w_resp_err) r_err_addr <= r_paddr;
          end
`ifdef APB_FABRIC_TIMEOUT_EN
          else begin
            r_cnt <= w_cnt_inc[CntW-1:0];
          end
`endif
        end
        ERR: begin
          r_err_addr <= r_paddr;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_fabric.sv
// Scoreboard bench for apb_periph_fabric: directed transfers, queued expected responses, decoupled monitor.
module tb_apb_periph_fabric;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_psel, s_penable, s_pwrite;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata, s_prdata;
  logic s_pready, s_pslverr;
  logic [NP*AW-1:0] addr_base, addr_last;
  logic [NP-1:0] m_psel;
  logic m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [NP*DW-1:0] m_prdata;
  logic [NP-1:0] m_pready, m_pslverr;
  logic err_valid;
  logic [AW-1:0] err_addr;

  apb_periph_fabric #(.NrPerip(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_psel_i(s_psel), .s_penable_i(s_penable), .s_pwrite_i(s_pwrite),
    .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_prdata_o(s_prdata),
    .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
    .addr_base_i(addr_base), .addr_last_i(addr_last),
    .m_psel_o(m_psel), .m_penable_o(m_penable), .m_pwrite_o(m_pwrite),
    .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .err_valid_o(err_valid), .err_addr_o(err_addr)
  );

  // Subordinate models: fixed read data, programmable wait states and error flag.
  logic [DW-1:0] cfg_rdata [NP];
  int            cfg_wait  [NP];
  logic          cfg_err   [NP];
  int            acc_cnt   [NP];

  always_comb begin
    m_prdata  = '0;
    m_pready  = '0;
    m_pslverr = '0;
    for (int i = 0; i < NP; i++) begin
      m_prdata[i*DW +: DW] = cfg_rdata[i];
      m_pready[i]  = m_psel[i] && m_penable && (acc_cnt[i] >= cfg_wait[i]);
      m_pslverr[i] = m_psel[i] && m_penable && cfg_err[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (!rst && m_psel[i] && m_penable && !m_pready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      else acc_cnt[i] <= 0;
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          chk_rd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed manager transfer.
  always @(negedge clk) begin
    if (err_valid) err_pulses++;
    if (!rst && s_psel && s_penable && s_pready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response actual=addr 0x%08h required=no response", s_paddr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_pslverr", 32'(s_pslverr), 32'(e.err));
        chk("resp_err_valid", 32'(err_valid), 32'(e.err));
        if (e.chk_rd) chk("resp_prdata", s_prdata, e.rdata);
      end
    end else if (err_valid) begin
      checks++;
      failures++;
      $display("FAIL stray_err_valid actual=1 required=0");
    end
  end

  task automatic set_map(input int i, input logic [AW-1:0] base, input logic [AW-1:0] last);
    addr_base[i*AW +: AW] = base;
    addr_last[i*AW +: AW] = last;
  endtask

  // Called at posedge+#1; returns at posedge+#1 of the cycle after the response.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] exp_rd, input logic exp_err, input logic chk_rd,
                      output int lat, output logic [NP-1:0] psel_or);
    exp_t e;
    e.rdata = exp_rd;
    e.err = exp_err;
    e.chk_rd = chk_rd;
    exp_q.push_back(e);
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wdata;
    psel_or = '0;
    lat = 0;
    @(negedge clk);
    psel_or |= m_psel;
    @(posedge clk); #1;
    s_penable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      lat++;
      @(negedge clk);
      psel_or |= m_psel;
      if (s_pready) break;
      @(posedge clk); #1;
    end
    if (!s_pready) begin
      checks++;
      failures++;
      $display("FAIL xfer_no_pready actual=none required=pready addr=0x%08h", addr);
    end
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  int lat;
  int pulses0;
  logic [NP-1:0] pso;

  initial begin
    rst = 1'b1;
    s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0; s_pwdata = '0;
    addr_base = '0; addr_last = '0;
    cfg_rdata[0] = 32'h0000_1111; cfg_rdata[1] = 32'hDEAD_BEEF;
    cfg_rdata[2] = 32'h2222_2222; cfg_rdata[3] = 32'h3333_3333;
    for (int i = 0; i < NP; i++) begin cfg_wait[i] = 0; cfg_err[i] = 1'b0; end
    set_map(0, 32'h0000_1000, 32'h0000_2000);
    set_map(1, 32'h0003_0000, 32'h0003_0100);
    set_map(2, 32'h0000_1800, 32'h0000_1900);
    set_map(3, 32'h0004_0000, 32'h0004_0100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_psel", 32'(m_psel), 32'h0);
    chk("rst_m_penable", 32'(m_penable), 32'h0);
    chk("rst_m_pwrite", 32'(m_pwrite), 32'h0);
    chk("rst_m_paddr", m_paddr, 32'h0);
    chk("rst_m_pwdata", m_pwdata, 32'h0);
    chk("rst_s_pready", 32'(s_pready), 32'h0);
    chk("rst_s_pslverr", 32'(s_pslverr), 32'h0);
    chk("rst_err_valid", 32'(err_valid), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mapped zero-wait read on port1.
    xfer(1'b0, 32'h0003_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, lat, pso);
    chk("rd_p1_latency", 32'(lat), 32'd2);
    chk("rd_p1_psel", 32'(pso), 32'b0010);
    chk("rd_p1_paddr", m_paddr, 32'h0003_0010);

    // Unmapped write.
    pulses0 = err_pulses;
    xfer(1'b1, 32'h0009_0000, 32'h1234_5678, 32'h0, 1'b1, 1'b1, lat, pso);
    chk("unmapped_latency", 32'(lat), 32'd1);
    chk("unmapped_psel", 32'(pso), 32'h0);
    chk("unmapped_pulses", 32'(err_pulses - pulses0), 32'd1);
    chk("unmapped_err_addr", err_addr, 32'h0009_0000);

    // Overlap: lowest index wins.
    xfer(1'b0, 32'h0000_1880, 32'h0, 32'h0000_1111, 1'b0, 1'b1, lat, pso);
    chk("overlap_psel", 32'(pso), 32'b0001);

    // Exclusive end and inclusive base.
    xfer(1'b0, 32'h0003_0100, 32'h0, 32'h0, 1'b1, 1'b1, lat, pso);
    chk("last_excl_latency", 32'(lat), 32'd1);
    xfer(1'b0, 32'h0003_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, lat, pso);
    chk("base_incl_psel", 32'(pso), 32'b0010);

    // A reversed range never matches.
    set_map(3, 32'h0006_0100, 32'h0006_0000);
    xfer(1'b0, 32'h0006_0050, 32'h0, 32'h0, 1'b1, 1'b1, lat, pso);
    chk("reversed_psel", 32'(pso), 32'h0);
    set_map(3, 32'h0004_0000, 32'h0004_0100);

    // Mapped write: broadcast registers carry the write.
    xfer(1'b1, 32'h0003_0020, 32'hCAFE_0001, 32'h0, 1'b0, 1'b0, lat, pso);
    chk("wr_pwdata", m_pwdata, 32'hCAFE_0001);
    chk("wr_pwrite", 32'(m_pwrite), 32'h1);
    chk("wr_psel", 32'(pso), 32'b0010);

    // Subordinate error on port3.
    cfg_err[3] = 1'b1;
    xfer(1'b0, 32'h0004_0004, 32'h0, 32'h3333_3333, 1'b1, 1'b1, lat, pso);
    chk("slverr_err_addr", err_addr, 32'h0004_0004);
    cfg_err[3] = 1'b0;

    // Two subordinate wait states on port0.
    cfg_wait[0] = 2;
    xfer(1'b0, 32'h0000_1000, 32'h0, 32'h0000_1111, 1'b0, 1'b1, lat, pso);
    chk("wait2_latency", 32'(lat), 32'd4);
    cfg_wait[0] = 0;

    // Back-to-back reads: port0 then port3.
    xfer(1'b0, 32'h0000_1004, 32'h0, 32'h0000_1111, 1'b0, 1'b1, lat, pso);
    chk("b2b_first_psel", 32'(pso), 32'b0001);
    xfer(1'b0, 32'h0004_0008, 32'h0, 32'h3333_3333, 1'b0, 1'b1, lat, pso);
    chk("b2b_second_latency", 32'(lat), 32'd2);
    chk("b2b_second_psel", 32'(pso), 32'b1000);

`ifdef APB_FABRIC_TIMEOUT_EN
    cfg_wait[3] = 100;
    xfer(1'b0, 32'h0004_0010, 32'h0, 32'h0, 1'b1, 1'b1, lat, pso);
    chk("timeout_latency", 32'(lat), 32'd5);
    chk("timeout_psel_drop", 32'(m_psel), 32'h0);
    chk("timeout_err_addr", err_addr, 32'h0004_0010);
    cfg_wait[3] = 3;
    xfer(1'b0, 32'h0004_0014, 32'h0, 32'h3333_3333, 1'b0, 1'b1, lat, pso);
    chk("late_ready_latency", 32'(lat), 32'd5);
`else
    cfg_wait[3] = 6;
    xfer(1'b0, 32'h0004_0014, 32'h0, 32'h3333_3333, 1'b0, 1'b1, lat, pso);
    chk("long_stall_latency", 32'(lat), 32'd8);
`endif
    cfg_wait[3] = 0;

    // Reset during ACCESS with a stalled port1.
    cfg_wait[1] = 100;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h0003_0040;
    @(posedge clk); #1;
    s_penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_penable", 32'(m_penable), 32'h1);
    chk("pre_rst_psel", 32'(m_psel), 32'b0010);
    @(posedge clk); #1;
    rst = 1'b1; s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_psel", 32'(m_psel), 32'h0);
    chk("midrst_penable", 32'(m_penable), 32'h0);
    chk("midrst_pready", 32'(s_pready), 32'h0);
    chk("midrst_paddr", m_paddr, 32'h0);
    chk("midrst_err_addr", err_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_wait[1] = 0;
    xfer(1'b0, 32'h0003_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, lat, pso);
    chk("post_rst_latency", 32'(lat), 32'd2);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
